// File: rtl/alu16_issue_ctrl_if.sv
// rtl/alu16_issue_ctrl_if.sv - instruction/result handshake bundle for alu16_issue_ctrl
interface alu16_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_c;
    logic [6:0]  res_flags;
    logic [5:0]  res_op;
    logic        err;

    modport master (
        output in_valid, in_op, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_c, res_flags, res_op, err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, res_ready,
        output in_ready, res_valid, res_c, res_flags, res_op, err
    );
endinterface

// File: rtl/alu16_issue_ctrl.sv
// rtl/alu16_issue_ctrl.sv - FIFO-fed issue/capture sequencer for alu16 (ALU16_OPCODE_CHECK_EN enables illegal-opcode rejection)
module alu16_issue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_WAIT  = 1,
    parameter int MULTI_WAIT = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    alu16_issue_ctrl_if.slave  bus,
    output logic [15:0]        alu_a,
    output logic [15:0]        alu_b,
    output logic [5:0]         alu_op,
    output logic               alu_enable,
    input  logic [31:0]        alu_c,
    input  logic [6:0]         alu_flags,
    output logic               busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BASE_WAIT + MULTI_WAIT + 1) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    logic [37:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] wait_cnt;
    logic          push;
    logic          pop;
    logic [37:0]   head;
    logic [5:0]    head_op;
    logic          head_multi;
    logic          head_illegal;
    logic          res_valid_q;
    logic [31:0]   res_c_q;
    logic [6:0]    res_flags_q;
    logic [5:0]    res_op_q;

    assign bus.in_ready  = (count != (AW + 1)'(FIFO_DEPTH));
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = (state == IDLE) && (count != '0);
    assign head          = mem[rd_ptr];
    assign head_op       = head[37:32];
    assign head_multi    = (head_op >= 6'd5) && (head_op <= 6'd8);
    assign busy          = (state != IDLE) || (count != '0);

    assign bus.res_valid = res_valid_q;
    assign bus.res_c     = res_c_q;
    assign bus.res_flags = res_flags_q;
    assign bus.res_op    = res_op_q;

`ifdef ALU16_OPCODE_CHECK_EN
    logic err_q;

    assign head_illegal = (head_op == 6'd0) || (head_op == 6'd31) ||
                          (head_op == 6'd32) || (head_op >= 6'd34);
    assign bus.err      = err_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (pop && head_illegal) begin
            err_q <= 1'b1;
        end else if (state == DONE && bus.res_ready) begin
            err_q <= 1'b0;
        end
    end
`else
    assign head_illegal = 1'b0;
    assign bus.err      = 1'b0;
`endif

    // Storage is not reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_op, bus.in_a, bus.in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Enable rises only on IDLE->WAIT and falls on WAIT->DONE, so each
    // instruction produces exactly one rising edge at alu16.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            alu_enable  <= 1'b0;
            wait_cnt    <= '0;
            res_valid_q <= 1'b0;
            res_c_q     <= '0;
            res_flags_q <= '0;
            res_op_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_illegal) begin
                            res_c_q     <= '0;
                            res_flags_q <= '0;
                            res_op_q    <= head_op;
                            res_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            alu_op     <= head_op;
                            alu_a      <= head[31:16];
                            alu_b      <= head[15:0];
                            alu_enable <= 1'b1;
                            wait_cnt   <= head_multi ? CW'(BASE_WAIT + MULTI_WAIT) : CW'(BASE_WAIT);
                            state      <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == CW'(1)) begin
                        res_c_q     <= alu_c;
                        res_flags_q <= alu_flags;
                        res_op_q    <= alu_op;
                        res_valid_q <= 1'b1;
                        alu_enable  <= 1'b0;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu16_issue_ctrl.md
Name: alu16_issue_ctrl

Overview:
Sequential front-end that sits directly upstream of the combinational alu16 and also captures its outputs. It buffers incoming instructions (op, a, b) in a small FIFO and drives alu16's a/b/op/enable one instruction at a time. It holds each operation stable for an op-dependent settle time, then registers c/flags into a result port with a valid/ready handshake. It also guarantees one clean enable pulse per instruction, so alu16's internal stack ops (push 29, pop 30, clear 33) execute exactly once.

Parameters:
FIFO_DEPTH, 4, instruction FIFO entries (power of two, >=2)
BASE_WAIT, 1, settle cycles for single-cycle ops (>=1)
MULTI_WAIT, 2, extra settle cycles added for ops 5..8 (mul, div, modulo, power)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  FIFO can accept; equals !full
in_op  in  6  opcode
in_a  in  16  operand a
in_b  in  16  operand b
alu_a  out  16  to alu16 a
alu_b  out  16  to alu16 b
alu_op  out  6  to alu16 op
alu_enable  out  1  to alu16 enable
alu_c  in  32  from alu16 c
alu_flags  in  7  from alu16 flags
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_c  out  32  captured result
res_flags  out  7  captured flags
res_op  out  6  opcode that produced the result
err  out  1  qualifies res_valid; illegal opcode (see Optional Feature)
busy  out  1  high when state != IDLE or FIFO non-empty

Behaviour:
- Reset (reset_n=0 at posedge): FIFO emptied, state=IDLE. alu_a, alu_b, alu_op, alu_enable, res_valid, res_c, res_flags, res_op and err all go to 0. in_ready=1 from the next cycle. Reset mid-operation abandons the in-flight instruction with no result.
- FIFO: write on in_valid&&in_ready. It pops only in IDLE. Write and pop in the same cycle are legal. When full, in_ready=0 and the FIFO contents are unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, WAIT, DONE.
- IDLE, FIFO non-empty: pop the head and register it into alu_a, alu_b and alu_op. Set alu_enable=1. Load wait counter N = BASE_WAIT, or BASE_WAIT+MULTI_WAIT for op 5..8. Go to WAIT.
- WAIT: decrement N each cycle. On the edge where N==1, capture alu_c->res_c, alu_flags->res_flags and alu_op->res_op. Set res_valid=1 and alu_enable=0, then go to DONE.
- DONE: hold res_* stable while res_valid && !res_ready. On res_ready, clear res_valid and go to IDLE.
- Latency, defaults: an instruction accepted at edge E0 gives alu_enable high from E1 and res_valid high from E2 for simple ops. For ops 5..8, res_valid rises at E4.
- Back-to-back throughput: alu_enable is low for at least 2 cycles (DONE + IDLE) between instructions. This is a fixed property: every instruction gives exactly one enable rising edge.
- alu_a, alu_b and alu_op hold their last values when alu_enable=0.
- No opcode decoding beyond the 5..8 settle selection. Flags and ops 24 (clear carry) and 25 (compare) pass through unchanged.

Optional Feature:
Macro ALU16_OPCODE_CHECK_EN.
- Defined: opcodes 0, 31, 32 and >=34 are illegal. An illegal instruction is popped in IDLE but never driven to alu16 (alu_enable stays 0). The FSM goes straight to DONE with res_c=0, res_flags=0, res_op=opcode and err=1. err clears with res_valid.
- Not defined: every opcode is issued normally and err is tied to 0.

Test Plan:
- Bench uses an alu16 stub: op1 returns a+b, op5 returns a*b, op29/30 count enable rising edges.
- Reset then idle -> all outputs 0, in_ready=1, busy=0. Assert reset_n=0 during WAIT -> res_valid never rises and the FIFO is empty afterward.
- Add: op=1, a=60000, b=60000, res_ready=1 -> alu_enable high 1 cycle, res_valid at E2, res_c=32'h0001D4C0, res_op=1.
- Multiply with backpressure: op=5, a=16'hFFFF, b=16'hFFFF, res_ready=0 for 5 cycles.
  - res_valid at E4, res_c=32'hFFFE0001, held stable until res_ready.
  - alu_enable high exactly 3 cycles.
- Fill and drain: 6 instructions offered continuously with res_ready=0.
  - in_ready falls after 4 FIFO writes plus 1 in flight.
  - Releasing res_ready drains all results in order.
  - Stub sees exactly 6 enable rising edges.
- Stack ops: push 5, push 365, pop, pop -> exactly 4 enable pulses, results returned in order with res_op = 29, 29, 30, 30.
- Illegal opcode: op=34 with ALU16_OPCODE_CHECK_EN -> alu_enable stays 0, res_valid with err=1, res_c=0. Without the macro -> issued, err=0.
